// File: rtl/stopwatch_pkg.sv
// Shared constants, state encoding and flash codes for the stopwatch time path.
package stopwatch_pkg;

  localparam int FIELD_W = 7;

  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 99;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    SET  = 2'd2
  } state_t;

  // One-hot marker of the field currently being edited.
  localparam logic [2:0] FL_MIN  = 3'b100;
  localparam logic [2:0] FL_SEC  = 3'b010;
  localparam logic [2:0] FL_CS   = 3'b001;
  localparam logic [2:0] FL_NONE = 3'b000;

endpackage

// File: rtl/stopwatch_timekeeper_field_counter.sv
// Single time field: counts 0..MAX and wraps. The carry flags the wrapping
// increment so the next field up can ride on it.
module field_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 99
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [FIELD_W-1:0] value,
  output logic               carry
);

  assign carry = inc && (value == FIELD_W'(MAX));

  // Field register: clear wins over increment; the increment wraps at MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= carry ? '0 : value + FIELD_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_timekeeper.sv
// Stopwatch timekeeper: 100 Hz prescaler, STOP/RUN/SET control and three
// chained field counters feeding the display controller.
module stopwatch_timekeeper
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        mode,
  input  logic        up,
  input  logic        clear,
  output logic [20:0] out_time,
  output logic [2:0]  flash,
  output logic        display_mode,
  output logic        running
);

  localparam int PW = $clog2(TICK_DIV);

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic [2:0]    flash_next;
  logic          running_next;
  logic          display_mode_next;

  // Only the highest-priority pulse in a cycle is allowed to act.
  logic act_clear;
  logic act_ss;
  logic act_mode;
  logic act_up;

  assign act_clear = clear;
  assign act_ss    = start_stop & ~clear;
  assign act_mode  = mode & ~clear & ~start_stop;
  assign act_up    = up & ~clear & ~start_stop & ~mode;

  // A terminal prescaler count in RUN is a tick; a coinciding clear or
  // start_stop discards it.
  logic tick;
  logic run_tick;

  assign tick     = (state == RUN) && (presc == PW'(TICK_DIV - 1));
  assign run_tick = tick & ~act_clear & ~act_ss;

  logic               set_up;
  logic               cs_inc;
  logic               sec_inc;
  logic               min_inc;
  logic               cs_carry;
  logic               sec_carry;
  logic               min_carry;
  logic [FIELD_W-1:0] cs_value;
  logic [FIELD_W-1:0] sec_value;
  logic [FIELD_W-1:0] min_value;

  // In RUN the fields form a carry chain; in SET each field only sees its
  // own gated up pulse so there is never a carry between fields.
  assign set_up  = (state == SET) & act_up;
  assign cs_inc  = (state == RUN) ? run_tick  : (set_up & flash[0]);
  assign sec_inc = (state == RUN) ? cs_carry  : (set_up & flash[1]);
  assign min_inc = (state == RUN) ? sec_carry : (set_up & flash[2]);

  field_counter #(.MAX(CS_MAX)) u_cs (
    .clk   (clk),
    .reset (reset),
    .clr   (act_clear),
    .inc   (cs_inc),
    .value (cs_value),
    .carry (cs_carry)
  );

  field_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .reset (reset),
    .clr   (act_clear),
    .inc   (sec_inc),
    .value (sec_value),
    .carry (sec_carry)
  );

  field_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .reset (reset),
    .clr   (act_clear),
    .inc   (min_inc),
    .value (min_value),
    .carry (min_carry)
  );

  assign out_time = {min_value, sec_value, cs_value};

  // State, prescaler and output flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= STOP;
      presc        <= '0;
      flash        <= FL_NONE;
      running      <= 1'b0;
      display_mode <= 1'b0;
    end else begin
      state        <= state_next;
      presc        <= presc_next;
      flash        <= flash_next;
      running      <= running_next;
      display_mode <= display_mode_next;
    end
  end

  // Next-state and prescaler decode.
  always_comb begin
    state_next = state;
    presc_next = '0;
    case (state)
      STOP: begin
        if (act_ss) begin
          state_next = RUN;
        end else if (act_mode) begin
          state_next = SET;
        end
      end
      RUN: begin
        if (act_ss) begin
          state_next = STOP;
        end else if (!act_clear) begin
          presc_next = tick ? '0 : presc + PW'(1);
        end
      end
      SET: begin
        if (act_mode && (flash == FL_CS)) begin
          state_next = STOP;
        end
      end
      default: state_next = STOP;
    endcase
  end

  // Next values of the registered flags, derived from the upcoming state.
  always_comb begin
    flash_next        = flash;
    running_next      = (state_next == RUN);
    display_mode_next = (state_next == SET);
    case (state)
      STOP: begin
        if (act_mode) begin
          flash_next = FL_MIN;
        end
      end
      SET: begin
        if (act_mode) begin
          case (flash)
            FL_MIN:  flash_next = FL_SEC;
            FL_SEC:  flash_next = FL_CS;
            default: flash_next = FL_NONE;
          endcase
        end
      end
      default: flash_next = flash;
    endcase
  end

  // The minute carry has no destination; the full wrap simply rolls over.
  logic unused_min_carry;
  assign unused_min_carry = min_carry;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// Self-checking bench: directed scenarios plus random button traffic, all
// compared against a time-arithmetic reference model.
`timescale 1ns/1ps
module tb_stopwatch_timekeeper;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_stop;
  logic        mode;
  logic        up;
  logic        clear;
  logic [20:0] out_time;
  logic [2:0]  flash;
  logic        display_mode;
  logic        running;

  stopwatch_timekeeper #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_stop   (start_stop),
    .mode         (mode),
    .up           (up),
    .clear        (clear),
    .out_time     (out_time),
    .flash        (flash),
    .display_mode (display_mode),
    .running      (running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time as three numbers, state as 0=STOP 1=RUN 2=SET,
  // edited field as 0=none 1=min 2=sec 3=cs. Ticks fall every TD cycles
  // counted from the cycle RUN was entered or last cleared.
  int m_min, m_sec, m_cs;
  int m_st;
  int m_fld;
  int cycle  = 0;
  int anchor = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tv(input int mi, input int se, input int c);
    logic [6:0] a, b, d;
    a = 7'(mi);
    b = 7'(se);
    d = 7'(c);
    return {11'd0, a, b, d};
  endfunction

  function automatic logic [2:0] model_flash();
    case (m_fld)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] model_vec();
    logic [20:0] t;
    t = tv(m_min, m_sec, m_cs) & 32'h1F_FFFF;
    return {6'd0, t, model_flash(), m_st == 2, m_st == 1};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {6'd0, out_time, flash, display_mode, running};
  endfunction

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_cs = 0;
    m_st  = 0; m_fld = 0;
  endtask

  task automatic model_zero();
    m_min = 0; m_sec = 0; m_cs = 0;
  endtask

  task automatic model_tick();
    int total;
    total = (m_min * 60 + m_sec) * 100 + m_cs;
    total = (total + 1) % (100 * 60 * 100);
    m_cs  = total % 100;
    m_sec = (total / 100) % 60;
    m_min = total / 6000;
  endtask

  task automatic model_edge(input bit c, input bit ss, input bit md, input bit u);
    cycle++;
    case (m_st)
      0: begin
        if (c) model_zero();
        else if (ss) begin m_st = 1; anchor = cycle; end
        else if (md) begin m_st = 2; m_fld = 1; end
      end
      1: begin
        if (c) begin model_zero(); anchor = cycle; end
        else if (ss) m_st = 0;
        else if (((cycle - anchor) % TD) == 0) model_tick();
      end
      default: begin
        if (c) model_zero();
        else if (ss) begin end
        else if (md) begin
          if (m_fld == 3) begin m_st = 0; m_fld = 0; end
          else m_fld++;
        end else if (u) begin
          case (m_fld)
            1: m_min = (m_min + 1) % 100;
            2: m_sec = (m_sec + 1) % 60;
            3: m_cs  = (m_cs + 1) % 100;
            default: begin end
          endcase
        end
      end
    endcase
  endtask

  task automatic step(input bit c, input bit ss, input bit md, input bit u);
    @(negedge clk);
    clear = c; start_stop = ss; mode = md; up = u;
    @(posedge clk);
    model_edge(c, ss, md, u);
    #1;
    check_value("state_vec", dut_vec(), model_vec());
    if (c | ss | md | u)
      $display("cycle %0d: clear=%0b start_stop=%0b mode=%0b up=%0b -> %0d:%0d:%0d flash=%03b set=%0b run=%0b",
               cycle, c, ss, md, u, out_time[20:14], out_time[13:7], out_time[6:0],
               flash, display_mode, running);
    clear = 1'b0; start_stop = 1'b0; mode = 1'b0; up = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  // From STOP with zero time, dial in a value through SET mode.
  task automatic set_time(input int mi, input int se, input int c);
    step(0, 0, 1, 0);
    press_up(mi);
    step(0, 0, 1, 0);
    press_up(se);
    step(0, 0, 1, 0);
    press_up(c);
    step(0, 0, 1, 0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_value("rst_time", {11'd0, out_time}, 32'd0);
    check_value("rst_flash", {29'd0, flash}, 32'd0);
    check_value("rst_dmode", {31'd0, display_mode}, 32'd0);
    check_value("rst_running", {31'd0, running}, 32'd0);
    @(posedge clk);
    cycle++;
    #1;
    check_value("rst_hold", dut_vec(), model_vec());
    @(negedge clk);
    reset = 1'b0;
    $display("cycle %0d: reset pulse", cycle);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_stop = 1'b0; mode = 1'b0; up = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_value("init_state", dut_vec(), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // up in STOP does nothing
    step(0, 0, 0, 1);
    check_value("up_in_stop", dut_vec(), 32'd0);

    // Carry chain
    step(0, 1, 0, 0);
    idle(400);
    check_value("carry_1s", {11'd0, out_time}, tv(0, 1, 0));
    idle(23600);
    check_value("carry_1m", {11'd0, out_time}, tv(1, 0, 0));
    check_value("carry_running", {31'd0, running}, 32'd1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);

    // Set every field to its maximum, then run through the full wrap
    set_time(99, 59, 99);
    check_value("set_max", {11'd0, out_time}, tv(99, 59, 99));
    check_value("set_exit_flash", {29'd0, flash}, 32'd0);
    check_value("set_exit_dmode", {31'd0, display_mode}, 32'd0);
    step(0, 1, 0, 0);
    idle(4);
    check_value("full_wrap", {11'd0, out_time}, 32'd0);
    check_value("wrap_running", {31'd0, running}, 32'd1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);

    // Set-mode wrap without carry
    step(0, 0, 1, 0);
    check_value("set_flash_min", {29'd0, flash}, 32'd4);
    check_value("set_dmode", {31'd0, display_mode}, 32'd1);
    press_up(3);
    check_value("set_min3", {11'd0, out_time}, tv(3, 0, 0));
    step(0, 0, 1, 0);
    check_value("set_flash_sec", {29'd0, flash}, 32'd2);
    press_up(60);
    check_value("sec_wrap_nocarry", {11'd0, out_time}, tv(3, 0, 0));
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check_value("set_done_flash", {29'd0, flash}, 32'd0);
    check_value("set_done_dmode", {31'd0, display_mode}, 32'd0);
    step(1, 0, 0, 0);

    // start_stop on a tick cycle discards the tick
    step(0, 1, 0, 0);
    idle(11);
    step(0, 1, 0, 0);
    check_value("ss_on_tick", {11'd0, out_time}, tv(0, 0, 2));
    check_value("ss_on_tick_run", {31'd0, running}, 32'd0);

    // clear beats start_stop in STOP
    step(1, 1, 0, 0);
    check_value("clr_ss_time", {11'd0, out_time}, 32'd0);
    check_value("clr_ss_run", {31'd0, running}, 32'd0);

    // clear in RUN restarts the tick phase
    set_time(0, 2, 50);
    step(0, 1, 0, 0);
    idle(2);
    check_value("pre_clear", {11'd0, out_time}, tv(0, 2, 50));
    step(1, 0, 0, 0);
    check_value("run_clear_time", {11'd0, out_time}, 32'd0);
    check_value("run_clear_run", {31'd0, running}, 32'd1);
    idle(3);
    check_value("run_clear_notick", {11'd0, out_time}, 32'd0);
    idle(1);
    check_value("run_clear_tick", {11'd0, out_time}, tv(0, 0, 1));

    // up and mode are ignored in RUN
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    check_value("ign_run_time", {11'd0, out_time}, tv(0, 0, 1));
    check_value("ign_run_dmode", {31'd0, display_mode}, 32'd0);
    check_value("ign_run_flash", {29'd0, flash}, 32'd0);
    step(0, 1, 0, 0);

    // start_stop is ignored in SET
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    check_value("ign_set_run", {31'd0, running}, 32'd0);
    check_value("ign_set_flash", {29'd0, flash}, 32'd4);
    check_value("ign_set_dmode", {31'd0, display_mode}, 32'd1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);

    // Reset mid-RUN at 00:05:37
    set_time(0, 5, 35);
    step(0, 1, 0, 0);
    idle(8);
    check_value("pre_reset", {11'd0, out_time}, tv(0, 5, 37));
    apply_reset();
    idle(5);
    check_value("post_reset_run", {31'd0, running}, 32'd0);
    check_value("post_reset_time", {11'd0, out_time}, 32'd0);

    // Random button traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        apply_reset();
      end else begin
        step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5,
             $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 25);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
